// File: rtl/bert_error_accumulator.sv
// bert_error_accumulator
// BERT sync supervisor and error accumulator. Compares each received bit
// against the aligned PN reference bit, runs HUNT/CHECK/LOCK acquisition
// (reseeding the reference LFSR via reload) and reports bit/error totals
// for every completed test window while locked.
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   enable                bit strobe, one received bit per high cycle
//   data, code            received bit and aligned reference bit
//   blackout              exclude current bit from statistics
//   window_bits           window length in counted bits (0 = no reporting)
//   acq_errors            max errors in a CHECK block to declare lock
//   loss_errors           LOCK block error count above which a block is bad
//   loss_blocks           consecutive bad blocks that drop lock (0 acts as 1)
//   reload                LFSR reseed request, qualified with enable
//   locked                high while in LOCK
//   result_valid          one-clock pulse when result registers update
//   result_bits/_errors   totals of the last completed window
//   sync_losses           saturating count of LOCK->HUNT transitions
module bert_error_accumulator #(
  parameter int CW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          data,
  input  logic          code,
  input  logic          blackout,
  input  logic [CW-1:0] window_bits,
  input  logic [6:0]    acq_errors,
  input  logic [6:0]    loss_errors,
  input  logic [3:0]    loss_blocks,
  output logic          reload,
  output logic          locked,
  output logic          result_valid,
  output logic [CW-1:0] result_bits,
  output logic [CW-1:0] result_errors,
  output logic [15:0]   sync_losses
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    CHECK = 2'd1,
    LOCK  = 2'd2
  } state_t;

  state_t        state_r, state_next_s;
  logic [4:0]    settle_r, settle_next_s;
  logic [5:0]    blk_cnt_r, blk_cnt_next_s;
  logic [6:0]    blk_err_r, blk_err_next_s;
  logic [3:0]    miss_r, miss_next_s;
  logic [CW-1:0] bit_acc_r, bit_acc_next_s;
  logic [CW-1:0] err_acc_r, err_acc_next_s;
  logic [CW-1:0] res_bits_r, res_errs_r;
  logic          res_valid_r;
  logic [15:0]   sync_losses_r;

  logic          counted_s, err_s, report_s, loss_s;
  logic [6:0]    blk_sum_s;
  logic [3:0]    miss_inc_s, loss_lim_s;
  logic [CW-1:0] bit_sat_s, err_sat_s;

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic inc);
    return (inc && (v != {CW{1'b1}})) ? v + {{(CW-1){1'b0}}, 1'b1} : v;
  endfunction

  assign counted_s  = enable & ~blackout;
  assign err_s      = data ^ code;
  // Block error total including the current bit's own error.
  assign blk_sum_s  = blk_err_r + {6'd0, err_s};
  assign miss_inc_s = miss_r + 4'd1;
  assign loss_lim_s = (loss_blocks == 4'd0) ? 4'd1 : loss_blocks;
  assign bit_sat_s  = sat_inc(bit_acc_r, 1'b1);
  assign err_sat_s  = sat_inc(err_acc_r, err_s);

  assign reload       = enable && (state_r == HUNT) && (settle_r == 5'd0);
  assign locked       = (state_r == LOCK);
  assign result_valid = res_valid_r;
  assign result_bits  = res_bits_r;
  assign result_errors = res_errs_r;
  assign sync_losses  = sync_losses_r;

  // Next-state and datapath next values; only applied on enable cycles.
  always_comb begin
    state_next_s   = state_r;
    settle_next_s  = settle_r;
    blk_cnt_next_s = blk_cnt_r;
    blk_err_next_s = blk_err_r;
    miss_next_s    = miss_r;
    bit_acc_next_s = bit_acc_r;
    err_acc_next_s = err_acc_r;
    report_s       = 1'b0;
    loss_s         = 1'b0;
    case (state_r)
      HUNT: begin
        // blackout is ignored here: every enable advances the settle count.
        settle_next_s = settle_r + 5'd1;
        if (settle_r == 5'd31) begin
          state_next_s   = CHECK;
          blk_cnt_next_s = 6'd0;
          blk_err_next_s = 7'd0;
        end else begin
          state_next_s = HUNT;
        end
      end
      CHECK: begin
        if (counted_s) begin
          if (blk_cnt_r == 6'd63) begin
            blk_cnt_next_s = 6'd0;
            blk_err_next_s = 7'd0;
            if (blk_sum_s <= acq_errors) begin
              state_next_s   = LOCK;
              miss_next_s    = 4'd0;
              bit_acc_next_s = {CW{1'b0}};
              err_acc_next_s = {CW{1'b0}};
            end else begin
              state_next_s  = HUNT;
              settle_next_s = 5'd0;
            end
          end else begin
            blk_cnt_next_s = blk_cnt_r + 6'd1;
            blk_err_next_s = blk_sum_s;
          end
        end else begin
          state_next_s = CHECK;
        end
      end
      LOCK: begin
        if (counted_s) begin
          // Window accounting; the report uses totals including this bit.
          if ((window_bits != {CW{1'b0}}) && (bit_sat_s == window_bits)) begin
            report_s       = 1'b1;
            bit_acc_next_s = {CW{1'b0}};
            err_acc_next_s = {CW{1'b0}};
          end else begin
            bit_acc_next_s = bit_sat_s;
            err_acc_next_s = err_sat_s;
          end
          // Block accounting runs independently of the window.
          if (blk_cnt_r == 6'd63) begin
            blk_cnt_next_s = 6'd0;
            blk_err_next_s = 7'd0;
            if (blk_sum_s > loss_errors) begin
              if (miss_inc_s >= loss_lim_s) begin
                state_next_s   = HUNT;
                settle_next_s  = 5'd0;
                miss_next_s    = 4'd0;
                loss_s         = 1'b1;
                bit_acc_next_s = {CW{1'b0}};
                err_acc_next_s = {CW{1'b0}};
              end else begin
                miss_next_s = miss_inc_s;
              end
            end else begin
              miss_next_s = 4'd0;
            end
          end else begin
            blk_cnt_next_s = blk_cnt_r + 6'd1;
            blk_err_next_s = blk_sum_s;
          end
        end else begin
          state_next_s = LOCK;
        end
      end
      default: begin
        state_next_s  = HUNT;
        settle_next_s = 5'd0;
      end
    endcase
  end

  // State and counter registers; result_valid self-clears every clock.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= HUNT;
      settle_r      <= 5'd0;
      blk_cnt_r     <= 6'd0;
      blk_err_r     <= 7'd0;
      miss_r        <= 4'd0;
      bit_acc_r     <= {CW{1'b0}};
      err_acc_r     <= {CW{1'b0}};
      res_bits_r    <= {CW{1'b0}};
      res_errs_r    <= {CW{1'b0}};
      res_valid_r   <= 1'b0;
      sync_losses_r <= 16'd0;
    end else begin
      res_valid_r <= 1'b0;
      if (enable) begin
        state_r   <= state_next_s;
        settle_r  <= settle_next_s;
        blk_cnt_r <= blk_cnt_next_s;
        blk_err_r <= blk_err_next_s;
        miss_r    <= miss_next_s;
        bit_acc_r <= bit_acc_next_s;
        err_acc_r <= err_acc_next_s;
        if (report_s) begin
          res_bits_r  <= bit_sat_s;
          res_errs_r  <= err_sat_s;
          res_valid_r <= 1'b1;
        end
        if (loss_s && (sync_losses_r != 16'hFFFF)) begin
          sync_losses_r <= sync_losses_r + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bert_error_accumulator.sv
// Scoreboard bench for bert_error_accumulator: expected window results are
// queued as stimulus is driven and compared when result_valid pulses.
module tb_bert_error_accumulator;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        data = 1'b0;
  logic        code = 1'b0;
  logic        blackout = 1'b0;
  logic [31:0] window_bits = 32'd1000;
  logic [6:0]  acq_errors = 7'd5;
  logic [6:0]  loss_errors = 7'd10;
  logic [3:0]  loss_blocks = 4'd3;
  logic        reload, locked, result_valid;
  logic [31:0] result_bits, result_errors;
  logic [15:0] sync_losses;

  typedef struct {
    logic [31:0] bits;
    logic [31:0] errs;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fails = 0;
  int reload_cnt = 0;
  int gap = 0;
  logic last_reload = 1'b0;

  bert_error_accumulator #(.CW(32)) dut (
    .clock(clock), .reset(reset), .enable(enable), .data(data), .code(code),
    .blackout(blackout), .window_bits(window_bits), .acq_errors(acq_errors),
    .loss_errors(loss_errors), .loss_blocks(loss_blocks), .reload(reload),
    .locked(locked), .result_valid(result_valid), .result_bits(result_bits),
    .result_errors(result_errors), .sync_losses(sync_losses)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One bit on the strobe, preceded by `gap` idle cycles.
  task automatic send_bit(input logic err, input logic bo);
    for (int g = 0; g < gap; g++) begin
      enable = 1'b0;
      @(posedge clock); #1;
    end
    enable   = 1'b1;
    data     = 1'($urandom_range(0, 1));
    code     = data ^ err;
    blackout = bo;
    #1;
    last_reload = reload;
    if (reload) reload_cnt++;
    @(posedge clock); #1;
    enable   = 1'b0;
    blackout = 1'b0;
  endtask

  // n bits; the first nerr of them carry an error.
  task automatic send_n(input int n, input int nerr);
    for (int i = 0; i < n; i++) send_bit(i < nerr, 1'b0);
  endtask

  // Scoreboard consumer: every result pulse must match the oldest expectation.
  always @(negedge clock) begin
    if (result_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_bits", {32'd0, result_bits}, {32'd0, e.bits});
        check("result_errors", {32'd0, result_errors}, {32'd0, e.errs});
      end
    end
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_locked", {63'd0, locked}, 64'd0);
    check("rst_valid", {63'd0, result_valid}, 64'd0);
    check("rst_bits", {32'd0, result_bits}, 64'd0);
    check("rst_errs", {32'd0, result_errors}, 64'd0);
    check("rst_losses", {48'd0, sync_losses}, 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    check("reload_idle", {63'd0, reload}, 64'd0);

    // Acquisition on a clean stream: 32 HUNT + 64 CHECK bits.
    send_bit(1'b0, 1'b0);
    check("first_reload", {63'd0, last_reload}, 64'd1);
    send_n(31 + 63, 0);
    check("not_locked_95", {63'd0, locked}, 64'd0);
    send_n(1, 0);
    check("locked_96", {63'd0, locked}, 64'd1);
    check("one_reload", reload_cnt, 64'd1);

    // Window 1: clean, 1000 bits.
    exp_q.push_back('{32'd1000, 32'd0});
    send_n(999, 0);
    check("no_early_valid", {63'd0, result_valid}, 64'd0);
    send_n(1, 0);
    check("valid_at_1000", {63'd0, result_valid}, 64'd1);

    // Window 2: three errors.
    exp_q.push_back('{32'd1000, 32'd3});
    send_n(1000, 3);
    check("still_locked", {63'd0, locked}, 64'd1);

    // Window 3: five blacked-out erroneous bits are not counted.
    exp_q.push_back('{32'd1000, 32'd2});
    send_n(500, 2);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
    send_n(499, 0);
    check("bo_no_early", {63'd0, result_valid}, 64'd0);
    send_n(1, 0);
    check("bo_valid_delayed", {63'd0, result_valid}, 64'd1);

    // 3000 counted bits since lock leave 56 bits into a block; realign.
    send_n(8, 0);
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 64; i++) send_bit(i[0], 1'b0);
      if (b < 2) check("lock_held_bad_blk", {63'd0, locked}, 64'd1);
    end
    check("lock_lost", {63'd0, locked}, 64'd0);
    check("sync_losses_1", {48'd0, sync_losses}, 64'd1);
    send_bit(1'b0, 1'b0);
    check("reload_after_loss", {63'd0, last_reload}, 64'd1);

    // Failed acquisition: 3 errors against acq_errors=2.
    acq_errors = 7'd2;
    send_n(31, 0);
    send_n(64, 3);
    check("check_fail_unlocked", {63'd0, locked}, 64'd0);
    send_bit(1'b0, 1'b0);
    check("reload_after_check", {63'd0, last_reload}, 64'd1);

    // Reacquire with a 1-of-4 strobe and a 100-bit window.
    acq_errors  = 7'd5;
    window_bits = 32'd100;
    gap = 3;
    send_n(31 + 64, 0);
    check("relock_sparse", {63'd0, locked}, 64'd1);
    exp_q.push_back('{32'd100, 32'd1});
    send_n(100, 1);
    send_n(50, 0);
    enable = 1'b0;
    #1;
    check("reload_low_no_en", {63'd0, reload}, 64'd0);

    // Reset mid-window: partial window must never be reported.
    reset = 1'b1;
    enable = 1'b1;
    @(posedge clock); #1;
    enable = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    check("mid_rst_locked", {63'd0, locked}, 64'd0);
    check("mid_rst_valid", {63'd0, result_valid}, 64'd0);
    check("mid_rst_bits", {32'd0, result_bits}, 64'd0);
    check("mid_rst_errs", {32'd0, result_errors}, 64'd0);
    check("mid_rst_losses", {48'd0, sync_losses}, 64'd0);
    send_bit(1'b0, 1'b0);
    check("reload_after_rst", {63'd0, last_reload}, 64'd1);
    send_n(31 + 64, 0);
    check("relock_after_rst", {63'd0, locked}, 64'd1);

    repeat (4) @(posedge clock);
    #1;
    check("queue_drained", exp_q.size(), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/bert_error_accumulator.md
# bert_error_accumulator

BERT sync supervisor and error accumulator. It sits downstream of `bert_slip_detect` and the PN reference LFSR. It compares received data against the reference code bit by bit and excludes bits flagged by `blackout`. It runs the HUNT/CHECK/LOCK acquisition state machine, which reseeds the LFSR through `reload`, and it reports bit/error totals per programmable test window.

## Interface
- `CW`, 32: width of window, bit and error counters.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  bit strobe; one received bit per high cycle.
- `data`  in  1  received bit.
- `code`  in  1  reference LFSR bit aligned to `data`.
- `blackout`  in  1  exclude current bit from all statistics (slip recovery).
- `window_bits`  in  CW  test window length in counted bits; 0 disables reporting.
- `acq_errors`  in  7  max errors in a 64-bit CHECK block to declare lock.
- `loss_errors`  in  7  errors in a 64-bit LOCK block above which the block is bad.
- `loss_blocks`  in  4  consecutive bad blocks that drop lock; 0 treated as 1.
- `reload`  out  1  LFSR reseed request, qualified with `enable`.
- `locked`  out  1  state == LOCK.
- `result_valid`  out  1  one-clock pulse; result registers updated.
- `result_bits`  out  CW  counted bits in last completed window.
- `result_errors`  out  CW  errors in last completed window.
- `sync_losses`  out  16  LOCK→HUNT transitions since reset, saturating.

## Operation
- A bit is counted when `enable && !blackout`. The error is `data ^ code`.
- States:
  - HUNT: 5-bit settle counter. `reload = enable && state==HUNT && settle==0` (combinational). Each enable increments settle. After 32 enables, go to CHECK with the block counters cleared. `blackout` is ignored in HUNT.
  - CHECK: 6-bit block counter and 7-bit error counter advance on counted bits. On the 64th counted bit, including its own error, go to LOCK if errors ≤ `acq_errors`, else go to HUNT.
  - LOCK: same 64-bit blocks. At each block end:
    - errors > `loss_errors` increments a 4-bit miss counter.
    - A good block clears the miss counter.
    - If misses reach `loss_blocks`, go to HUNT and increment `sync_losses`.
- Window accumulation runs only in LOCK, on counted bits.
  - `bit_acc` and `err_acc` are saturating at 2^CW−1.
  - When `bit_acc` reaches `window_bits` (including the current bit), copy both totals to `result_bits` and `result_errors`, pulse `result_valid`, and clear the accumulators.
  - Entering LOCK clears the accumulators. Leaving LOCK discards a partial window without reporting.
  - A window end and a block end on the same bit are both processed; the result covers the full window.
- `window_bits` must be held stable while locked. Changing it takes effect at the next comparison.

## Timing
- All registers update on `posedge clock` only when `enable` is high, except reset. Only `enable` cycles advance state.
- Reset values:
  - state HUNT; all counters 0.
  - `locked` = 0, `result_valid` = 0, `result_bits` = 0, `result_errors` = 0, `sync_losses` = 0.
  - `reload` is 0 while `enable` is low. It is high on the first enable after reset.
- Reset mid-window clears everything. No result is reported.
- Transitions take effect on the edge ending the decisive bit:
  - `locked` rises the clock after the 64th CHECK bit and falls the clock after the final bad block.
- `result_valid` is registered and high for exactly one clock after the window-ending bit. The result registers hold until the next window.
- `reload` is high for exactly one enable per HUNT visit. The LFSR consumes it in the same cycle.
- Latency from HUNT entry to the earliest `locked`: 32 + 64 enables when `blackout` is low.

## Test plan
- Error-free PN stream after reset, `enable` continuous, `window_bits`=1000 → exactly one `reload` at the first enable; `locked` rises after bit 96; `result_valid` after 1000 further bits with bits=1000, errors=0.
- Inject 3 errors per 1000 bits while locked, `window_bits`=1000 → `result_errors`=3 each window; `locked` stays 1.
- `acq_errors`=2, 3 errors in the CHECK block → returns to HUNT, second `reload` issued, `locked` stays 0.
- Locked, `loss_errors`=10, `loss_blocks`=3, three consecutive 64-bit blocks of 32 errors → `locked` falls after the third block end; `sync_losses`=1; next `reload` on the following enable.
- `blackout` high for 5 bits mid-window, errors forced on those bits → `result_bits`=`window_bits`, those errors not counted, window end delayed by 5 enables.
- `enable` toggled 1-of-4 with `reset` asserted mid-window → all outputs return to reset values; no `result_valid`; acquisition restarts.
